// File: rtl/ram_stream_reader.sv
// ram_stream_reader: turns a (start address, length) command into a burst of
// 1-cycle-latency RAM reads and delivers the words as a valid/ready stream
// with a last marker. A 2-entry output buffer plus credit-based issue keeps
// backpressure lossless.
// Build option: RAM_STREAM_READER_BYTE_ADDR_EN selects byte addressing
// (address step DW/8); the default is word addressing (step 1).
module ram_stream_reader #(
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 32,
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW-1:0]    start_addr,
    input  logic [LEN_W-1:0] length,
    output logic             busy,
    output logic             done,
    output logic             ren,
    output logic [AW-1:0]    r_addr,
    input  logic [DW-1:0]    r_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DW-1:0]    m_data,
    output logic             m_last
);

`ifdef RAM_STREAM_READER_BYTE_ADDR_EN
    localparam int unsigned ADDR_STEP = DW / 8;
`else
    localparam int unsigned ADDR_STEP = 1;
`endif
    localparam logic [AW-1:0] STEP = AW'(ADDR_STEP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [AW-1:0]     addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issue_cnt;
    logic [LEN_W-1:0]  beat_cnt;
    logic              inflight;
    logic              inflight_last;
    logic              done_q;

    logic [DW-1:0]     buf_data [2];
    logic              buf_last [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        count;

    logic              pop;
    logic              issue_last;
    logic              beat_last;
    logic              accept;
    logic              zero_start;
    logic [1:0]        occ;

    assign m_valid    = (count != 2'd0);
    assign pop        = m_valid & m_ready;
    assign issue_last = (issue_cnt == len_q - LEN_W'(1));
    assign beat_last  = (beat_cnt == len_q - LEN_W'(1));
    // Words held or still returning from the RAM after this cycle's pop.
    assign occ        = count + {1'b0, inflight} - {1'b0, pop};

    assign busy   = (state != IDLE);
    assign done   = done_q;
    assign r_addr = addr_q;
    assign m_data = buf_data[rd_ptr];
    assign m_last = m_valid & buf_last[rd_ptr];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic, read issue under credit, command acceptance.
    always_comb begin
        state_next = state;
        ren        = 1'b0;
        accept     = 1'b0;
        zero_start = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        accept     = 1'b1;
                        state_next = READ;
                    end else begin
                        zero_start = 1'b1;
                    end
                end
            end
            READ: begin
                if (occ < 2'd2) begin
                    ren = 1'b1;
                    if (issue_last) state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && beat_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Command registers, issue/beat counters, in-flight tracking, done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q        <= '0;
            len_q         <= '0;
            issue_cnt     <= '0;
            beat_cnt      <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q        <= zero_start | ((state == DRAIN) & pop & beat_last);
            inflight      <= ren;
            inflight_last <= ren & issue_last;
            if (accept) begin
                addr_q    <= start_addr;
                len_q     <= length;
                issue_cnt <= '0;
                beat_cnt  <= '0;
            end else begin
                if (ren) begin
                    issue_cnt <= issue_cnt + LEN_W'(1);
                    // Final read leaves r_addr on the last issued address.
                    if (!issue_last) addr_q <= addr_q + STEP;
                end
                if (pop) beat_cnt <= beat_cnt + LEN_W'(1);
            end
        end
    end

    // Output buffer: capture read data the cycle after ren, pop on handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_last[0] <= 1'b0;
            buf_last[1] <= 1'b0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= '0;
        end else begin
            if (inflight) begin
                buf_data[wr_ptr] <= r_data;
                buf_last[wr_ptr] <= inflight_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, inflight} - {1'b0, pop};
        end
    end

endmodule

// File: doc/ram_stream_reader.md
# ram_stream_reader

Read-side initiator for the single-clock dual-port RAM. It turns a (start address, length) command into a burst of RAM reads on the RAM read port (ren/r_addr/r_data, 1-cycle read latency) and delivers the returned words as a valid/ready stream with a last marker. It sits between a dual-port RAM instance and a stream consumer such as a DMA engine or an instruction prefetch path. Internally it has a 2-entry output buffer and credit-based read issue, so backpressure never drops or duplicates a word.

## Interface
- DW, 32, data width; must match the RAM.
- AW, 32, address width; must match the RAM.
- LEN_W, 16, width of the burst length field.

- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  command strobe; sampled only in IDLE.
- start_addr  in  AW  first RAM address of the burst.
- length  in  LEN_W  number of words to read; 0 is legal.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  single-cycle pulse when the burst completes.
- ren  out  1  RAM read enable.
- r_addr  out  AW  RAM read address.
- r_data  in  DW  RAM read data; valid the cycle after ren.
- m_valid  out  1  output word valid.
- m_ready  in  1  consumer accepts the word.
- m_data  out  DW  output word.
- m_last  out  1  high with the final word of the burst.

## Operation
- States:
  - IDLE: waits for start.
  - READ: issues reads.
  - DRAIN: all reads issued; waits for the output buffer to empty.
- Transitions:
  - IDLE→READ: start=1 and length≠0. Latch start_addr and length.
  - IDLE→IDLE: start=1 and length=0. done pulses next cycle; no ren.
  - READ→DRAIN: the cycle the final ren is issued.
  - DRAIN→IDLE: the cycle the last beat is accepted (m_valid&m_ready&m_last).
- start outside IDLE is ignored.
- Counters:
  - issue counter counts reads issued.
  - beat counter counts words accepted.
  - Both are LEN_W bits wide.
- Credit rule: ren=1 in READ only when (buffer_count + inflight − pop) < 2, where pop = m_valid&m_ready and inflight is ren registered one cycle.
- Capture: r_data is written into the buffer in the cycle after each ren, unconditionally; credit guarantees space.
- Output order is issue order.
- m_last is attached to the word whose issue index equals length−1.
- Address increment: by ADDR_STEP per issued read, modulo 2^AW; wrap from all-ones to 0 is silent.
- Outputs not under ren are don't-care but held stable: r_addr holds its last value.
- m_data and m_last must hold stable while m_valid=1 and m_ready=0.
- Reset (any cycle, including mid-burst):
  - state=IDLE; counters, buffer, and inflight cleared.
  - A read issued in the reset cycle is discarded.
  - busy=0, done=0, ren=0, m_valid=0, m_last=0, r_addr=0, m_data=0.

## Timing
- start sampled at edge T0; busy=1 and the first ren with r_addr=start_addr in cycle T1.
- r_data is valid in T2 and captured at the end of T2; m_valid=1 in T3.
- Start-to-first-valid latency: 3 cycles.
- With m_ready held high: one ren per cycle and one beat per cycle, sustained.
- With m_ready=0: at most 2 words are buffered/in flight, and ren stops after 2 outstanding.
- done pulses in the cycle after the last beat is accepted; busy falls in the same cycle.
- A new start may be accepted the same cycle done=1.
- For length=0: done in T1, busy never rises.

## Configuration
- RAM_STREAM_READER_BYTE_ADDR_EN:
  - Defined: ADDR_STEP = DW/8, for byte-addressed RAM wrappers.
  - Undefined (default): ADDR_STEP = 1, word addressing matching direct memory[r_addr] indexing.
- Nothing else changes.

## Test plan
- Burst, no backpressure: start_addr=0x10, length=4, m_ready=1, RAM preloaded with mem[0x10..0x13]=A,B,C,D.
  - ren in T1–T4 at 0x10–0x13.
  - m_data A,B,C,D in T3–T6, m_last in T6.
  - done in T7.
- Backpressure: as above but m_ready=0 for T3–T8.
  - ren only at 0x10 and 0x11; m_valid=1 with m_data=A held stable.
  - After release, all 4 words arrive in order, with no duplicates.
- Zero length: start with length=0.
  - No ren; done=1 next cycle; busy stays 0.
- Address wrap, AW=8: start_addr=0xFE, length=4.
  - r_addr sequence 0xFE, 0xFF, 0x00, 0x01; data order preserved.
- Reset mid-burst: rst=1 for one cycle after the 2nd beat of a length=8 burst.
  - All outputs return to reset values the next cycle.
  - A fresh start (addr=0, length=1) completes correctly with no stale word.
- Ignored start and macro:
  - start pulsed during busy: no change to the burst.
  - With RAM_STREAM_READER_BYTE_ADDR_EN and DW=32: start_addr=0x100, length=3 → r_addr 0x100, 0x104, 0x108.
